// File: rtl/wt_loader_if.sv
// Write-side handshake bundle for the weight loader.
interface wt_loader_if #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned CHANNELS = 8
);
   logic                wr_valid;
   logic [CHANNELS-1:0] wr_selOneHot;
   logic [WIDTH-1:0]    wr_data;
   logic                wr_ready;

   modport master (output wr_valid, wr_selOneHot, wr_data, input wr_ready);
   modport slave  (input wr_valid, wr_selOneHot, wr_data, output wr_ready);
endinterface

// File: rtl/wt_loader.sv
// Weight register file: sweeps default weights after reset, then commits
// one-hot-addressed writes one cycle after acceptance.
module wt_loader #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned CHANNELS = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   wt_loader_if.slave                wr,
   output logic [CHANNELS*WIDTH-1:0] dataOutBus,
   output logic [CHANNELS-1:0]       update_pulse,
   output logic                      err_onehot,
   output logic                      init_done,
   input  logic                      scan_in0,
   input  logic                      scan_in1,
   input  logic                      scan_in2,
   input  logic                      scan_in3,
   input  logic                      scan_in4,
   input  logic                      scan_enable,
   input  logic                      test_mode,
   output logic                      scan_out0,
   output logic                      scan_out1,
   output logic                      scan_out2,
   output logic                      scan_out3,
   output logic                      scan_out4
);

   localparam int unsigned CW = $clog2(CHANNELS);

   localparam logic [1:0] S_INIT   = 2'd0;
   localparam logic [1:0] S_IDLE   = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;

   logic [1:0]                     state_q, state_d;
   logic [CW-1:0]                  cnt_q, cnt_d;
   logic [CHANNELS-1:0][WIDTH-1:0] wt_q, wt_d;
   logic [CHANNELS-1:0]            update_pulse_q, update_pulse_d;
   logic [CHANNELS-1:0]            sel_q, sel_d;
   logic [WIDTH-1:0]               data_q, data_d;
   logic                           err_onehot_q, err_onehot_d;
   logic                           init_done_q, init_done_d;
   logic                           wr_ready_q, wr_ready_d;
   logic                           sel_onehot_c;
   logic                           unused_dft_c;

   // Captured select is usable only with exactly one bit set.
   assign sel_onehot_c = (sel_q != '0) &&
                         ((sel_q & (sel_q - CHANNELS'(1))) == '0);

   // DFT pins are placeholders for scan insertion.
   assign unused_dft_c = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                           scan_enable, test_mode};

   // Next-state, register-file update and output flags.
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      wt_d           = wt_q;
      update_pulse_d = '0;
      err_onehot_d   = 1'b0;
      sel_d          = sel_q;
      data_d         = data_q;
      init_done_d    = init_done_q;
      case (state_q)
         S_INIT: begin
            wt_d[cnt_q]           = WIDTH'((32'(cnt_q) + 32'd1) << 1);
            update_pulse_d[cnt_q] = 1'b1;
            cnt_d                 = cnt_q + CW'(1);
            if (cnt_q == CW'(CHANNELS - 1)) begin
               state_d     = S_IDLE;
               init_done_d = 1'b1;
               cnt_d       = '0;
            end
         end
         S_IDLE: begin
            if (wr.wr_valid) begin
               sel_d   = wr.wr_selOneHot;
               data_d  = wr.wr_data;
               state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            if (sel_onehot_c) begin
               for (int unsigned j = 0; j < CHANNELS; j++) begin
                  if (sel_q[j]) wt_d[j] = data_q;
               end
               update_pulse_d = sel_q;
            end else begin
               err_onehot_d = 1'b1;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_INIT;
      endcase
      wr_ready_d = (state_d == S_IDLE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_INIT;
         cnt_q          <= '0;
         wt_q           <= '0;
         update_pulse_q <= '0;
         sel_q          <= '0;
         data_q         <= '0;
         err_onehot_q   <= 1'b0;
         init_done_q    <= 1'b0;
         wr_ready_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         wt_q           <= wt_d;
         update_pulse_q <= update_pulse_d;
         sel_q          <= sel_d;
         data_q         <= data_d;
         err_onehot_q   <= err_onehot_d;
         init_done_q    <= init_done_d;
         wr_ready_q     <= wr_ready_d;
      end
   end

   assign dataOutBus   = wt_q;
   assign update_pulse = update_pulse_q;
   assign err_onehot   = err_onehot_q;
   assign init_done    = init_done_q;
   assign wr.wr_ready  = wr_ready_q;
   assign scan_out0    = 1'b0;
   assign scan_out1    = 1'b0;
   assign scan_out2    = 1'b0;
   assign scan_out3    = 1'b0;
   assign scan_out4    = 1'b0;

endmodule

// File: tb/tb_wt_loader.sv
// Self-checking bench for wt_loader: directed scenarios plus random traffic
// compared every cycle against a transaction-level model.
module tb_wt_loader;
   localparam int W  = 32;
   localparam int CH = 8;
   localparam int BW = CH * W;

   logic          clk = 1'b0;
   logic          reset;
   logic [BW-1:0] bus;
   logic [CH-1:0] upd;
   logic          err, done;
   logic          si0, si1, si2, si3, si4, sen, tmode;
   logic          so0, so1, so2, so3, so4;

   int n_checks = 0;
   int n_pass   = 0;

   wt_loader_if #(.WIDTH(W), .CHANNELS(CH)) wr();

   wt_loader #(.WIDTH(W), .CHANNELS(CH)) dut (
      .clk(clk), .reset(reset), .wr(wr),
      .dataOutBus(bus), .update_pulse(upd), .err_onehot(err), .init_done(done),
      .scan_in0(si0), .scan_in1(si1), .scan_in2(si2), .scan_in3(si3), .scan_in4(si4),
      .scan_enable(sen), .test_mode(tmode),
      .scan_out0(so0), .scan_out1(so1), .scan_out2(so2), .scan_out3(so3), .scan_out4(so4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Transaction-level model: default sweep, then accept/commit pairs.
   logic [W-1:0]  m_w [CH];
   logic [CH-1:0] m_pulse;
   logic          m_err, m_done, m_ready;
   int            sweep;
   bit            pend;
   logic [CH-1:0] p_sel;
   logic [W-1:0]  p_data;
   bit            started = 0;

   always @(posedge clk) begin
      if (reset) begin
         for (int j = 0; j < CH; j++) m_w[j] = '0;
         m_pulse = '0;
         m_err   = 1'b0;
         sweep   = 0;
         pend    = 0;
      end else begin
         m_pulse = '0;
         m_err   = 1'b0;
         if (sweep < CH) begin
            m_w[sweep]     = W'(2 * (sweep + 1));
            m_pulse[sweep] = 1'b1;
            sweep++;
         end else if (pend) begin
            pend = 0;
            if ($countones(p_sel) == 1) begin
               for (int j = 0; j < CH; j++) if (p_sel[j]) m_w[j] = p_data;
               m_pulse = p_sel;
            end else begin
               m_err = 1'b1;
            end
         end else if (wr.wr_valid) begin
            pend   = 1;
            p_sel  = wr.wr_selOneHot;
            p_data = wr.wr_data;
         end
      end
      m_done  = (sweep == CH);
      m_ready = m_done && !pend;
      started = 1;
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      logic [BW-1:0] eb;
      if (started) begin
         for (int j = 0; j < CH; j++) eb[j*W +: W] = m_w[j];
         chk("model_bus", bus, eb);
         chk("model_update_pulse", BW'(upd), BW'(m_pulse));
         chk("model_err_onehot", BW'(err), BW'(m_err));
         chk("model_init_done", BW'(done), BW'(m_done));
         chk("model_wr_ready", BW'(wr.wr_ready), BW'(m_ready));
         chk("pulse_err_exclusive", BW'((|upd) & err), '0);
         chk("scan_out_zero", BW'({so4, so3, so2, so1, so0}), '0);
      end
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Hold wr_valid until accepted; returns at the negedge after acceptance.
   task automatic do_write(input logic [CH-1:0] s, input logic [W-1:0] d);
      bit ok = 0;
      wr.wr_valid     = 1'b1;
      wr.wr_selOneHot = s;
      wr.wr_data      = d;
      for (int i = 0; i < 40 && !ok; i++) begin
         if (wr.wr_ready === 1'b1) ok = 1;
         step();
      end
      wr.wr_valid = 1'b0;
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL write_timeout: got no wr_ready expected accept within 40 cycles");
   endtask

   logic [BW-1:0] defaults;

   initial begin
      defaults = {32'd16, 32'd14, 32'd12, 32'd10, 32'd8, 32'd6, 32'd4, 32'd2};
      reset = 1'b1;
      wr.wr_valid = 1'b0; wr.wr_selOneHot = '0; wr.wr_data = '0;
      {si0, si1, si2, si3, si4, sen, tmode} = '0;

      // Reset for two edges.
      step();
      chk("reset_bus", bus, '0);
      chk("reset_ready", BW'(wr.wr_ready), '0);
      step();
      chk("reset_done", BW'(done), '0);
      reset = 1'b0;
      repeat (7) step();
      chk("init_not_done_7", BW'(done), '0);
      step();
      chk("init_defaults", bus, defaults);
      chk("init_done_8", BW'(done), BW'(1));
      chk("init_ready_8", BW'(wr.wr_ready), BW'(1));

      // Single write to channel 2.
      do_write(8'h04, 32'hDEADBEEF);
      chk("commit_ready_low", BW'(wr.wr_ready), '0);
      step();
      chk("ch2_written", BW'(bus[95:64]), BW'(32'hDEADBEEF));
      chk("ch2_pulse", BW'(upd), BW'(8'h04));
      chk("ch2_ready_back", BW'(wr.wr_ready), BW'(1));
      chk("ch2_others_low", BW'(bus[63:0]), BW'({32'd4, 32'd2}));
      chk("ch2_others_high", BW'(bus[255:96]), BW'({32'd16, 32'd14, 32'd12, 32'd10, 32'd8}));

      // Invalid selects.
      do_write(8'h05, 32'h12345678);
      step();
      chk("sel05_err", BW'(err), BW'(1));
      chk("sel05_pulse", BW'(upd), '0);
      do_write(8'h00, 32'h87654321);
      step();
      chk("sel00_err", BW'(err), BW'(1));
      chk("sel00_bus", BW'(bus[95:64]), BW'(32'hDEADBEEF));
      step();
      chk("err_one_cycle", BW'(err), '0);

      // Back-to-back with valid held.
      wr.wr_valid = 1'b1; wr.wr_selOneHot = 8'h01; wr.wr_data = 32'h11;
      step();
      wr.wr_selOneHot = 8'h80; wr.wr_data = 32'h77;
      step();
      chk("b2b_pulse0", BW'(upd), BW'(8'h01));
      chk("b2b_ch0", BW'(bus[31:0]), BW'(32'h11));
      step();
      wr.wr_valid = 1'b0;
      chk("b2b_pulse1", BW'(upd), '0);
      step();
      chk("b2b_pulse2", BW'(upd), BW'(8'h80));
      chk("b2b_ch7", BW'(bus[255:224]), BW'(32'h77));

      // Reset during commit.
      do_write(8'h02, 32'hFF);
      reset = 1'b1;
      step();
      chk("rst_commit_bus", bus, '0);
      chk("rst_commit_pulse", BW'(upd), '0);
      reset = 1'b0;
      repeat (8) step();
      chk("rst_commit_reinit", bus, defaults);

      // Valid during INIT is ignored.
      reset = 1'b1;
      step();
      reset = 1'b0;
      wr.wr_valid = 1'b1; wr.wr_selOneHot = 8'h01; wr.wr_data = 32'hAA;
      repeat (4) begin
         step();
         chk("init_valid_no_err", BW'(err), '0);
      end
      wr.wr_valid = 1'b0;
      repeat (4) step();
      chk("init_valid_ch0", BW'(bus[31:0]), BW'(32'd2));
      chk("init_valid_defaults", bus, defaults);

      // Random traffic.
      for (int i = 0; i < 500; i++) begin
         reset       = ($urandom_range(0, 99) == 0);
         wr.wr_valid = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) < 7) wr.wr_selOneHot = CH'(1) << $urandom_range(0, CH - 1);
         else wr.wr_selOneHot = CH'($urandom);
         wr.wr_data = $urandom;
         step();
      end
      reset = 1'b0;
      wr.wr_valid = 1'b0;
      repeat (12) step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/wt_loader.md
WT_LOADER -- requirements
Module: wt_loader

Interface
REQ-001 Parameter WIDTH, default 32, bit width of one channel weight.
REQ-002 Parameter CHANNELS, default 8, number of weight channels (power of two, >= 2).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; sampled on rising clk edge only.
REQ-005 wr_valid  input  1  write request valid.
REQ-006 wr_selOneHot  input  CHANNELS  one-hot target channel of write.
REQ-007 wr_data  input  WIDTH  weight value to write.
REQ-008 wr_ready  output  1  block can accept a write this cycle.
REQ-009 dataOutBus  output  CHANNELS*WIDTH  packed weights; channel j at bits [j*WIDTH +: WIDTH]; drives the weight mux dataInBus.
REQ-010 update_pulse  output  CHANNELS  one-cycle one-hot flag of the channel committed this cycle.
REQ-011 err_onehot  output  1  one-cycle pulse: accepted write carried an invalid select.
REQ-012 init_done  output  1  default weight sweep complete.
REQ-013 scan_in0..scan_in4, scan_enable, test_mode  input  1 each  DFT hooks; no functional effect in RTL.
REQ-014 scan_out0..scan_out4  output  1 each  DFT hooks; driven 0 in RTL.

Function
REQ-015 FSM states SHALL be INIT, IDLE, COMMIT; reset forces INIT with channel counter = 0.
REQ-016 INIT: each cycle writes channel cnt with default weight 2*(cnt+1) (WIDTH bits), pulses update_pulse bit cnt, increments cnt.
REQ-017 INIT -> IDLE on the cycle writing channel CHANNELS-1; init_done rises with entry to IDLE and stays 1 until reset.
REQ-018 wr_ready SHALL be 1 only in IDLE; 0 in INIT and COMMIT.
REQ-019 Handshake: write accepted when wr_valid & wr_ready at a rising edge; wr_selOneHot and wr_data captured into holding registers at that edge; IDLE -> COMMIT.
REQ-020 COMMIT: if captured select has exactly one bit set, that channel's field of dataOutBus SHALL be loaded at the edge ending COMMIT, update_pulse shows that bit for the same following cycle; COMMIT -> IDLE unconditionally.
REQ-021 Latency: accept at edge N, dataOutBus and update_pulse change at edge N+1; maximum throughput one write per two cycles.
REQ-022 Invalid select (zero or >1 bits set): write still accepted, no channel modified, update_pulse = 0, err_onehot = 1 for the one cycle following edge N+1.
REQ-023 wr_valid while wr_ready = 0 SHALL be ignored and not queued; initiator holds wr_valid until accepted.
REQ-024 Repeat writes to same channel: last committed value wins; untouched channels retain value indefinitely.
REQ-025 update_pulse and err_onehot SHALL never be asserted simultaneously; update_pulse at most one bit set.
REQ-026 Counter wrap: cnt width clog2(CHANNELS); no wrap occurs since INIT exits at CHANNELS-1.

Reset
REQ-027 While reset = 1 at an edge: dataOutBus = 0, update_pulse = 0, err_onehot = 0, init_done = 0, wr_ready = 0, cnt = 0, holding registers = 0, state = INIT.
REQ-028 Reset SHALL override all activity including a pending COMMIT (captured write discarded) and a partial INIT sweep (restarts from channel 0).
REQ-029 First INIT write occurs at first edge with reset = 0; init_done = 1 after CHANNELS such edges.

Verification
REQ-030 Reset 2 cycles, release -> bus all 0 during reset; after 8 edges dataOutBus = {16,14,12,10,8,6,4,2} (32-bit fields, ch7..ch0), init_done = 1, wr_ready = 1.
REQ-031 After init, write sel=8'h04 data=32'hDEADBEEF -> next edge bits[95:64] = DEADBEEF, update_pulse = 8'h04, wr_ready low exactly one cycle, other channels unchanged.
REQ-032 Writes with sel=8'h05 then 8'h00 -> err_onehot pulses once per write, update_pulse = 0, dataOutBus unchanged.
REQ-033 wr_valid held high, ch0=32'h11 then ch7=32'h77 -> both committed within 4 cycles, update_pulse sequence 01,00,80.
REQ-034 Reset asserted during COMMIT of sel=8'h02 data=32'hFF -> no write, bus cleared, INIT re-runs to defaults.
REQ-035 wr_valid asserted during INIT with sel=8'h01 data=32'hAA and dropped before IDLE -> channel 0 stays 2, no err_onehot.
